mips_lsu_avalon: RTL and testbench

Parametrised load/store unit that turns one decoded MIPS memory instruction into a single Avalon-MM master transaction and returns a write-back result. Sits between the multi-cycle CPU core's EXEC stage and the data-side Avalon bus. It provides proper byte-lane steering, sign extension, LWL/LWR merging, misalignment detection and waitrequest-stable requests for any power-of-two data width.

---
 rtl/mips_lsu_avalon_pkg.sv | 24 ++
 rtl/mips_lsu_avalon_lane_align.sv | 80 ++++++++
 rtl/mips_lsu_avalon.sv | 153 +++++++++++++++
 tb/tb_mips_lsu_avalon.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_avalon_pkg.sv
// Shared CPU definitions: memory-op and LSU state encodings plus small op classifiers.
package mips_cpu_definitions;

    typedef enum logic [3:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_BUS, ST_RESP
    } lsu_state_t;

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_half(input mem_op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic op_is_word(input mem_op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_lsu_avalon_lane_align.sv
// Combinational byte-lane steering: byteenables, store replication, load extension and LWL/LWR merge.
module mips_lsu_lane_align
    import mips_cpu_definitions::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned N      = DATA_W / 8,
    localparam int unsigned K      = $clog2(N)
) (
    input  mem_op_t             op,
    input  logic [K-1:0]        k,
    input  logic [DATA_W-1:0]   rt,
    input  logic [DATA_W-1:0]   readdata,
    output logic [N-1:0]        byteenable,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   rsp_data
);

    localparam int unsigned SHW = $clog2(DATA_W);
    localparam logic [N-1:0]      BE_ALL = '1;
    localparam logic [DATA_W-1:0] ONES   = '1;

    logic [SHW-1:0] sh_k;
    logic [SHW-1:0] sh_lwl;
    logic [15:0]    lane_w;

    // N-1-k equals ~k in K bits, so the LWL shift needs no subtractor.
    assign sh_k   = {k, 3'b000};
    assign sh_lwl = {~k, 3'b000};
    assign lane_w = 16'(readdata >> sh_k);

    always_comb begin
        byteenable = '0;
        writedata  = '0;
        rsp_data   = '0;
        case (op)
            OP_LB: begin
                byteenable = N'(1) << k;
                rsp_data   = {{(DATA_W-8){lane_w[7]}}, lane_w[7:0]};
            end
            OP_LBU: begin
                byteenable = N'(1) << k;
                rsp_data   = DATA_W'(lane_w[7:0]);
            end
            OP_LH: begin
                byteenable = N'(3) << k;
                rsp_data   = {{(DATA_W-16){lane_w[15]}}, lane_w};
            end
            OP_LHU: begin
                byteenable = N'(3) << k;
                rsp_data   = DATA_W'(lane_w);
            end
            OP_LW: begin
                byteenable = BE_ALL;
                rsp_data   = readdata;
            end
            OP_LWL: begin
                byteenable = ~((BE_ALL << k) << 1);
                rsp_data   = (readdata << sh_lwl) | (rt & ~(ONES << sh_lwl));
            end
            OP_LWR: begin
                byteenable = BE_ALL << k;
                rsp_data   = (readdata >> sh_k) | (rt & ~(ONES >> sh_k));
            end
            OP_SB: begin
                byteenable = N'(1) << k;
                writedata  = {N{rt[7:0]}};
            end
            OP_SH: begin
                byteenable = N'(3) << k;
                writedata  = {(N/2){rt[15:0]}};
            end
            OP_SW: begin
                byteenable = BE_ALL;
                writedata  = rt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_lsu_avalon.sv
// Load/store unit: one decoded MIPS memory op becomes one Avalon-MM transaction with a registered result.
module mips_lsu_avalon
    import mips_cpu_definitions::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned N      = DATA_W / 8,
    localparam int unsigned K      = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  mem_op_t             req_op,
    input  logic [ADDR_W-1:0]   req_base,
    input  logic [15:0]         req_offset,
    input  logic [DATA_W-1:0]   req_rt,
    input  logic [4:0]          req_dest,
    output logic                rsp_valid,
    output logic                rsp_we,
    output logic [4:0]          rsp_dest,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [N-1:0]        byteenable,
    input  logic [DATA_W-1:0]   readdata
);

    lsu_state_t          state_q;
    mem_op_t             op_q;
    logic [K-1:0]        k_q;
    logic [DATA_W-1:0]   rt_q;
    logic                req_ready_q, read_q, write_q;
    logic                rsp_valid_q, rsp_we_q, rsp_err_q;
    logic [4:0]          rsp_dest_q;
    logic [DATA_W-1:0]   rsp_data_q, writedata_q;
    logic [ADDR_W-1:0]   address_q;
    logic [N-1:0]        byteenable_q;

    logic [ADDR_W-1:0]   ea;
    logic [K-1:0]        k;
    logic                misaligned;
    logic                in_idle;
    mem_op_t             al_op;
    logic [K-1:0]        al_k;
    logic [DATA_W-1:0]   al_rt;
    logic [N-1:0]        al_be;
    logic [DATA_W-1:0]   al_wd;
    logic [DATA_W-1:0]   al_rsp;

    assign ea         = req_base + ADDR_W'($signed(req_offset));
    assign k          = ea[K-1:0];
    assign misaligned = (op_is_half(req_op) && ea[0]) || (op_is_word(req_op) && (k != '0));

    // One aligner serves both phases: request fields in IDLE, latched fields once in flight.
    assign in_idle = (state_q == ST_IDLE);
    assign al_op   = in_idle ? req_op : op_q;
    assign al_k    = in_idle ? k      : k_q;
    assign al_rt   = in_idle ? req_rt : rt_q;

    mips_lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .op         (al_op),
        .k          (al_k),
        .rt         (al_rt),
        .readdata   (readdata),
        .byteenable (al_be),
        .writedata  (al_wd),
        .rsp_data   (al_rsp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LB;
            k_q          <= '0;
            rt_q         <= '0;
            req_ready_q  <= 1'b1;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_we_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_dest_q   <= '0;
            rsp_data_q   <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q         <= req_op;
                        k_q          <= k;
                        rt_q         <= req_rt;
                        rsp_dest_q   <= req_dest;
                        address_q    <= {ea[ADDR_W-1:K], {K{1'b0}}};
                        byteenable_q <= al_be;
                        writedata_q  <= al_wd;
                        req_ready_q  <= 1'b0;
                        if (misaligned) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_we_q    <= 1'b0;
                            rsp_data_q  <= '0;
                            state_q     <= ST_RESP;
                        end else begin
                            read_q  <= ~op_is_store(req_op);
                            write_q <= op_is_store(req_op);
                            state_q <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (!waitrequest) begin
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_we_q    <= ~op_is_store(op_q);
                        rsp_data_q  <= op_is_store(op_q) ? '0 : al_rsp;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_we_q    <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign read       = read_q;
    assign write      = write_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_we     = rsp_we_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_dest   = rsp_dest_q;
    assign rsp_data   = rsp_data_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_lsu_avalon.sv
// Directed bench for mips_lsu_avalon: 32-bit instance for the main cases, 64-bit instance for lane merges.
module tb_mips_lsu_avalon;
    import mips_cpu_definitions::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 32-bit DUT signals
    logic        req_valid, req_ready, rsp_valid, rsp_we, rsp_err, read, write, waitrequest;
    mem_op_t     req_op;
    logic [31:0] req_base, req_rt, rsp_data, address, writedata, readdata;
    logic [15:0] req_offset;
    logic [4:0]  req_dest, rsp_dest;
    logic [3:0]  byteenable;

    // 64-bit DUT signals
    logic        v_valid, v_ready, v_rsp_valid, v_rsp_we, v_rsp_err, v_read, v_write, v_wait;
    mem_op_t     v_op;
    logic [31:0] v_base, v_address;
    logic [15:0] v_offset;
    logic [63:0] v_rt, v_rsp_data, v_writedata, v_readdata;
    logic [4:0]  v_dest, v_rsp_dest;
    logic [7:0]  v_be;

    mips_lsu_avalon #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_base(req_base), .req_offset(req_offset), .req_rt(req_rt),
        .req_dest(req_dest), .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_dest(rsp_dest),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .address(address), .read(read),
        .write(write), .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    mips_lsu_avalon #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset(reset), .req_valid(v_valid), .req_ready(v_ready),
        .req_op(v_op), .req_base(v_base), .req_offset(v_offset), .req_rt(v_rt),
        .req_dest(v_dest), .rsp_valid(v_rsp_valid), .rsp_we(v_rsp_we), .rsp_dest(v_rsp_dest),
        .rsp_data(v_rsp_data), .rsp_err(v_rsp_err), .address(v_address), .read(v_read),
        .write(v_write), .waitrequest(v_wait), .writedata(v_writedata),
        .byteenable(v_be), .readdata(v_readdata)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observations of the last 32-bit transaction
    int unsigned t_rd, t_wr, t_lat, t_rdy, t_nrsp;
    logic        t_stable, t_we, t_err;
    logic [31:0] t_addr, t_wd, t_data;
    logic [3:0]  t_be;
    logic [4:0]  t_dest;

    // Called #1 after a rising edge with the DUT idle; runs a fixed 16-cycle window.
    task automatic xact(input mem_op_t op, input logic [31:0] base, input logic [15:0] off,
                        input logic [31:0] rt, input logic [4:0] dest,
                        input int unsigned waits, input logic [31:0] rdata);
        int unsigned strobes;
        req_valid = 1'b1; req_op = op; req_base = base; req_offset = off;
        req_rt = rt; req_dest = dest; waitrequest = 1'b0; readdata = rdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        strobes = 0; t_rd = 0; t_wr = 0; t_lat = 0; t_rdy = 0; t_nrsp = 0; t_stable = 1'b1;
        t_addr = '0; t_wd = '0; t_be = '0; t_data = '0; t_we = 1'b0; t_err = 1'b0; t_dest = '0;
        for (int unsigned cyc = 1; cyc <= 16; cyc++) begin
            if (read || write) begin
                if (strobes == 0) begin
                    t_addr = address; t_be = byteenable; t_wd = writedata;
                end else if (address !== t_addr || byteenable !== t_be || writedata !== t_wd) begin
                    t_stable = 1'b0;
                end
                if (read)  t_rd++;
                if (write) t_wr++;
                strobes++;
                waitrequest = (strobes <= waits);
            end else begin
                waitrequest = 1'b0;
            end
            if (rsp_valid) begin
                t_nrsp++;
                if (t_nrsp == 1) begin
                    t_lat = cyc; t_data = rsp_data; t_we = rsp_we; t_err = rsp_err; t_dest = rsp_dest;
                end
            end
            if (req_ready && t_rdy == 0) t_rdy = cyc;
            @(posedge clk); #1;
        end
    endtask

    logic [63:0] v_got;
    logic [7:0]  v_got_be;
    int unsigned v_seen;

    task automatic xact64(input mem_op_t op, input logic [31:0] base, input logic [63:0] rt,
                          input logic [63:0] rdata);
        v_valid = 1'b1; v_op = op; v_base = base; v_offset = 16'd0; v_rt = rt;
        v_readdata = rdata; v_wait = 1'b0;
        @(posedge clk); #1;
        v_valid = 1'b0;
        v_seen = 0; v_got = '0; v_got_be = '0;
        for (int unsigned cyc = 1; cyc <= 8; cyc++) begin
            if (v_read) v_got_be = v_be;
            if (v_rsp_valid) begin
                v_seen++;
                v_got = v_rsp_data;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seen;
        reset = 1'b1;
        req_valid = 1'b0; req_op = OP_LW; req_base = '0; req_offset = '0; req_rt = '0;
        req_dest = '0; waitrequest = 1'b0; readdata = '0;
        v_valid = 1'b0; v_op = OP_LW; v_base = '0; v_offset = '0; v_rt = '0;
        v_dest = 5'd9; v_wait = 1'b0; v_readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_strobes", {read, write, rsp_valid, rsp_we, rsp_err}, 0);
        check_eq("rst_regs", {address, writedata, byteenable, rsp_data, rsp_dest}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        xact(OP_LW, 32'h1000, 16'd4, 32'h0, 5'd7, 0, 32'hDEADBEEF);
        check_eq("lw_addr", t_addr, 32'h1004);
        check_eq("lw_be", t_be, 4'b1111);
        check_eq("lw_read_cycles", t_rd, 1);
        check_eq("lw_write_cycles", t_wr, 0);
        check_eq("lw_data", t_data, 32'hDEADBEEF);
        check_eq("lw_we_err", {t_we, t_err}, 2'b10);
        check_eq("lw_dest", t_dest, 5'd7);
        check_eq("lw_latency", t_lat, 2);
        check_eq("lw_nrsp", t_nrsp, 1);
        check_eq("lw_ready_again", t_rdy, 3);

        xact(OP_LB, 32'h1000, 16'd3, 32'h0, 5'd1, 0, 32'h80112233);
        check_eq("lb_be", t_be, 4'b1000);
        check_eq("lb_addr", t_addr, 32'h1000);
        check_eq("lb_data", t_data, 32'hFFFFFF80);
        xact(OP_LBU, 32'h1000, 16'd3, 32'h0, 5'd1, 0, 32'h80112233);
        check_eq("lbu_data", t_data, 32'h00000080);

        xact(OP_LH, 32'h1000, 16'd2, 32'h0, 5'd2, 0, 32'h80017F00);
        check_eq("lh_be", t_be, 4'b1100);
        check_eq("lh_data", t_data, 32'hFFFF8001);
        xact(OP_LHU, 32'h1000, 16'd0, 32'h0, 5'd2, 0, 32'h80017F00);
        check_eq("lhu_data", t_data, 32'h00007F00);

        // negative offset: 0x2010 - 14 = 0x2002
        xact(OP_SH, 32'h2010, 16'hFFF2, 32'h0000ABCD, 5'd3, 3, 32'h0);
        check_eq("sh_write_cycles", t_wr, 4);
        check_eq("sh_read_cycles", t_rd, 0);
        check_eq("sh_addr", t_addr, 32'h2000);
        check_eq("sh_be", t_be, 4'b1100);
        check_eq("sh_wd", t_wd, 32'hABCDABCD);
        check_eq("sh_stable", t_stable, 1);
        check_eq("sh_nrsp", t_nrsp, 1);
        check_eq("sh_latency", t_lat, 5);
        check_eq("sh_we_data", {t_we, t_data}, 0);

        xact(OP_SB, 32'h4001, 16'd0, 32'h1234565A, 5'd4, 0, 32'h0);
        check_eq("sb_be", t_be, 4'b0010);
        check_eq("sb_wd", t_wd, 32'h5A5A5A5A);
        xact(OP_SW, 32'h4000, 16'd0, 32'h12345678, 5'd4, 1, 32'h0);
        check_eq("sw_wd", t_wd, 32'h12345678);
        check_eq("sw_be", t_be, 4'b1111);

        xact(OP_LWL, 32'h3001, 16'd0, 32'h11223344, 5'd5, 0, 32'hAABBCCDD);
        check_eq("lwl_be", t_be, 4'b0011);
        check_eq("lwl_data", t_data, 32'hCCDD3344);
        xact(OP_LWR, 32'h3001, 16'd0, 32'h11223344, 5'd5, 0, 32'hAABBCCDD);
        check_eq("lwr_be", t_be, 4'b1110);
        check_eq("lwr_data", t_data, 32'h11AABBCC);

        // address arithmetic wraps modulo 2^32
        xact(OP_LW, 32'hFFFFFFFC, 16'd8, 32'h0, 5'd6, 0, 32'h01020304);
        check_eq("wrap_addr", t_addr, 32'h00000004);

        xact(OP_LW, 32'h1000, 16'd2, 32'h0, 5'd8, 0, 32'hFFFFFFFF);
        check_eq("mis_strobes", t_rd + t_wr, 0);
        check_eq("mis_latency", t_lat, 1);
        check_eq("mis_err_we", {t_err, t_we}, 2'b10);
        check_eq("mis_data", t_data, 0);
        check_eq("mis_dest", t_dest, 5'd8);
        xact(OP_SH, 32'h1001, 16'd0, 32'h0, 5'd8, 0, 32'h0);
        check_eq("mis_sh_err", {t_err, t_rd + t_wr}, 33'h1_0000_0000);

        // reset while stalled in BUS
        req_valid = 1'b1; req_op = OP_LW; req_base = 32'h5000; req_offset = '0; waitrequest = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rstbus_read_before", read, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; waitrequest = 1'b0;
        check_eq("rstbus_read_after", read, 0);
        check_eq("rstbus_ready", req_ready, 1);
        check_eq("rstbus_rsp_valid", rsp_valid, 0);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid || read) seen++;
        end
        check_eq("rstbus_no_rsp", seen, 0);

        // 64-bit lane merges at k=5
        xact64(OP_LWL, 32'h105, 64'h1122334455667788, 64'hA1A2A3A4A5A6A7A8);
        check_eq("lwl64_be", v_got_be, 8'b0011_1111);
        check_eq("lwl64_data", v_got, 64'hA3A4A5A6A7A87788);
        check_eq("lwl64_nrsp", v_seen, 1);
        xact64(OP_LWR, 32'h105, 64'h1122334455667788, 64'hA1A2A3A4A5A6A7A8);
        check_eq("lwr64_be", v_got_be, 8'b1110_0000);
        check_eq("lwr64_data", v_got, 64'h1122334455A1A2A3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
